// File: rtl/serial_rx_frame_pkg.sv
// Shared serial-comm definitions: default word width, frame length, line levels
// and the receiver state type.
package serial_rx_frame_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int FRAME_W    = DATA_W_DEF + 2;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_t;
endpackage

// File: rtl/serial_rx_frame_if.sv
// Serial line in, held word plus status flags out; master is the line driver and consumer.
interface serial_rx_frame_if #(parameter int DATA_W = 8);
    logic              serial_in;
    logic              rd_ack;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport slave (
        input  serial_in, rd_ack,
        output rx_data, rx_valid, frame_err, overrun, busy
    );

    modport master (
        output serial_in, rd_ack,
        input  rx_data, rx_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_rx_frame_sipo.sv
// Serial-in parallel-out shift register with a saturating bit counter; cnt_done
// flags the edge that shifts in the last data bit.
module sipo_shift #(
    parameter int DATA_W = 8
) (
    input  logic              SRclk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] par_out,
    output logic              cnt_done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;

    always_ff @(posedge SRclk or posedge reset) begin
        if (reset) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else begin
            // Counter stops at DATA_W so it can never wrap back to zero.
            if (clear)
                bit_cnt_reg <= '0;
            else if (shift_en && (bit_cnt_reg != CNT_W'(DATA_W)))
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (shift_en)
                shift_reg <= {shift_reg[DATA_W-2:0], serial_in};
        end
    end

    assign par_out  = shift_reg;
    assign cnt_done = shift_en && (bit_cnt_reg == CNT_W'(DATA_W - 1));
endmodule

// File: rtl/serial_rx_frame.sv
// Bit-rate serial frame receiver: start bit, DATA_W bits MSB-first, stop bit,
// with a one-word holding register, frame-error and overrun flags.
module serial_rx_frame
    import serial_rx_frame_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic            SRclk,
    input  logic            reset,
    serial_rx_frame_if.slave bus
);
    rx_state_t         state_reg, state_next;
    logic              clear, shift_en, complete, cnt_done;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg, frame_err_reg, overrun_reg;

    sipo_shift #(.DATA_W(DATA_W)) u_sipo (
        .SRclk     (SRclk),
        .reset     (reset),
        .clear     (clear),
        .shift_en  (shift_en),
        .serial_in (bus.serial_in),
        .par_out   (word),
        .cnt_done  (cnt_done)
    );

    always_ff @(posedge SRclk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        clear      = 1'b0;
        shift_en   = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.serial_in == START_BIT) begin
                    state_next = DATA;
                    clear      = 1'b1;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (cnt_done) state_next = STOP;
            end
            STOP: begin
                // Stop bit is consumed here whatever its value, so a bad stop
                // bit is never mistaken for the next start bit.
                complete   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge SRclk or posedge reset) begin
        if (reset) begin
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (complete) begin
            if (!rx_valid_reg || bus.rd_ack) begin
                rx_data_reg   <= word;
                rx_valid_reg  <= 1'b1;
                frame_err_reg <= (bus.serial_in != STOP_BIT);
                overrun_reg   <= 1'b0;
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (bus.rd_ack && rx_valid_reg) begin
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end
    end

    assign bus.rx_data   = rx_data_reg;
    assign bus.rx_valid  = rx_valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_serial_rx_frame.sv
// Directed-frame bench for serial_rx_frame: a frame-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_serial_rx_frame;
    import serial_rx_frame_pkg::*;

    localparam int DW = 8;

    logic SRclk = 1'b0;
    logic reset = 1'b1;

    serial_rx_frame_if #(.DATA_W(DW)) bus ();

    serial_rx_frame #(.DATA_W(DW)) dut (
        .SRclk (SRclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 SRclk = ~SRclk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Frame-level model: -1 = waiting for start, 0..DW = data bits collected,
    // DW means the next line bit is the stop bit.
    int m_pos   = -1;
    int m_word  = 0;
    int m_data  = 0;
    bit m_valid = 0;
    bit m_ferr  = 0;
    bit m_ovr   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = -1; m_word = 0; m_data = 0;
        m_valid = 0; m_ferr = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input bit b, input bit a);
        bit done;
        done = 0;
        if (m_pos < 0) begin
            if (b == 0) begin m_pos = 0; m_word = 0; end
        end else if (m_pos < DW) begin
            m_word = (m_word * 2 + int'(b)) % (1 << DW);
            m_pos++;
        end else begin
            done  = 1;
            m_pos = -1;
        end
        if (done) begin
            if (!m_valid || a) begin
                m_data = m_word; m_valid = 1; m_ferr = !b; m_ovr = 0;
            end else begin
                m_ovr = 1;
            end
        end else if (a && m_valid) begin
            m_valid = 0; m_ferr = 0; m_ovr = 0;
        end
    endtask

    // One line bit per edge; called just after a rising edge.
    task automatic step(input bit b, input bit a);
        bus.serial_in = b;
        bus.rd_ack    = a;
        @(posedge SRclk);
        model_edge(b, a);
        #1;
    endtask

    task automatic send_frame(input int d, input bit stop, input bit ack_on_stop);
        step(0, 0);
        for (int i = DW - 1; i >= 0; i--) step(((d >> i) & 1) != 0, 0);
        step(stop, ack_on_stop);
    endtask

    always @(negedge SRclk) begin
        if (chk_en) begin
            chk("cyc_rx_data",   int'(bus.rx_data),   m_data);
            chk("cyc_rx_valid",  int'(bus.rx_valid),  int'(m_valid));
            chk("cyc_frame_err", int'(bus.frame_err), int'(m_ferr));
            chk("cyc_overrun",   int'(bus.overrun),   int'(m_ovr));
            chk("cyc_busy",      int'(bus.busy),      (m_pos >= 0) ? 1 : 0);
        end
    end

    initial begin
        bus.serial_in = LINE_IDLE;
        bus.rd_ack    = 1'b0;
        model_reset();
        #2;
        chk("reset_rx_data",  int'(bus.rx_data),  0);
        chk("reset_rx_valid", int'(bus.rx_valid), 0);
        chk("reset_busy",     int'(bus.busy),     0);
        @(posedge SRclk); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        step(1, 0);

        // Scenario 1: 0xA5, good stop bit
        send_frame(8'hA5, 1, 0);
        chk("s1_rx_data",   int'(bus.rx_data),   8'hA5);
        chk("s1_rx_valid",  int'(bus.rx_valid),  1);
        chk("s1_frame_err", int'(bus.frame_err), 0);
        chk("s1_busy",      int'(bus.busy),      0);
        step(1, 1);
        chk("s1_ack_valid", int'(bus.rx_valid), 0);
        $display("tb: scenario 1 frame 0xA5 done");

        // Scenario 2: 0x3C with stop bit 0
        send_frame(8'h3C, 0, 0);
        chk("s2_rx_data",   int'(bus.rx_data),   8'h3C);
        chk("s2_rx_valid",  int'(bus.rx_valid),  1);
        chk("s2_frame_err", int'(bus.frame_err), 1);
        step(1, 0);
        chk("s2_idle_busy", int'(bus.busy), 0);
        step(1, 1);
        chk("s2_ack_ferr", int'(bus.frame_err), 0);
        $display("tb: scenario 2 frame 0x3C bad stop done");

        // Scenario 3: back-to-back, no ack
        send_frame(8'h11, 1, 0);
        send_frame(8'h22, 1, 0);
        chk("s3_rx_data",  int'(bus.rx_data),  8'h11);
        chk("s3_rx_valid", int'(bus.rx_valid), 1);
        chk("s3_overrun",  int'(bus.overrun),  1);
        step(1, 1);
        chk("s3_ack_overrun", int'(bus.overrun), 0);
        $display("tb: scenario 3 overrun done");

        // Scenario 4: back-to-back, ack on second stop edge
        send_frame(8'h11, 1, 0);
        send_frame(8'h22, 1, 1);
        chk("s4_rx_data",  int'(bus.rx_data),  8'h22);
        chk("s4_rx_valid", int'(bus.rx_valid), 1);
        chk("s4_overrun",  int'(bus.overrun),  0);
        step(1, 1);
        $display("tb: scenario 4 ack-on-stop done");

        // Scenario 5: reset mid-frame, then a clean frame
        send_frame(8'h77, 1, 0);
        step(0, 0);
        for (int i = 0; i < 4; i++) step(1, 0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("s5_rst_rx_data",   int'(bus.rx_data),   0);
        chk("s5_rst_rx_valid",  int'(bus.rx_valid),  0);
        chk("s5_rst_frame_err", int'(bus.frame_err), 0);
        chk("s5_rst_overrun",   int'(bus.overrun),   0);
        chk("s5_rst_busy",      int'(bus.busy),      0);
        bus.serial_in = 1'b1;
        @(posedge SRclk); #1;
        reset = 1'b0;
        step(1, 0);
        send_frame(8'h5A, 1, 0);
        chk("s5_rx_data",   int'(bus.rx_data),   8'h5A);
        chk("s5_frame_err", int'(bus.frame_err), 0);
        step(1, 1);
        $display("tb: scenario 5 reset mid-frame done");

        // Scenario 6: long idle, stray acks
        for (int i = 0; i < 30; i++) step(1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1);
            step(1, 0);
        end
        chk("s6_rx_valid", int'(bus.rx_valid), 0);
        chk("s6_busy",     int'(bus.busy),     0);
        chk("s6_overrun",  int'(bus.overrun),  0);
        $display("tb: scenario 6 idle/stray ack done");

        @(negedge SRclk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
